// File: rtl/led_ctrl_if.sv
// Configuration bus for led_ctrl: one write port that selects a channel and
// sets that channel's mode and brightness.
interface led_ctrl_if #(
    parameter int IDX_W    = 2,
    parameter int PWM_BITS = 8
);
    // CFG_WE is a one-cycle write strobe with no ready. The slave takes the
    // write on every edge where CFG_WE is high. A write to an index at or
    // beyond NUM_LEDS is dropped and does nothing.
    logic                CFG_WE;
    logic [IDX_W-1:0]    CFG_IDX;
    logic [1:0]          CFG_MODE;
    logic [PWM_BITS-1:0] CFG_LEVEL;

    modport master (output CFG_WE, CFG_IDX, CFG_MODE, CFG_LEVEL);
    modport slave  (input  CFG_WE, CFG_IDX, CFG_MODE, CFG_LEVEL);
endinterface

// File: rtl/led_ctrl.sv
// Board status block: builds SYS_RST from RST_N and a debounced push-button,
// and drives NUM_LEDS status LEDs, each with its own mode and PWM brightness.
module led_ctrl #(
    parameter int                  NUM_LEDS        = 3,
    parameter int                  IDX_W           = 2,
    parameter int                  RST_CYCLES_LOG2 = 25,
    parameter int                  DEBOUNCE_LOG2   = 16,
    parameter int                  PWM_BITS        = 8,
    parameter int                  BLINK_DIV_LOG2  = 23,
    parameter int                  STRETCH_LOG2    = 22,
    parameter logic [NUM_LEDS-1:0] RST_PATTERN     = NUM_LEDS'(3'b101),
    parameter bit                  ACTIVE_LOW      = 1'b0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                SW_N,
    output logic                SYS_RST,
    led_ctrl_if.slave           cfg,
    input  logic [NUM_LEDS-1:0] ACTIVITY,
    output logic [NUM_LEDS-1:0] LED
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_ACT   = 2'd3
    } mode_e;

    localparam logic [STRETCH_LOG2:0] STRETCH_LOAD = {1'b1, {STRETCH_LOG2{1'b0}}};

    logic [1:0]                 sync;
    logic                       deb;
    logic [DEBOUNCE_LOG2-1:0]   dcnt;
    logic [RST_CYCLES_LOG2:0]   rcnt;
    logic [PWM_BITS-1:0]        pwm_cnt;
    logic [BLINK_DIV_LOG2-1:0]  blink_cnt;
    mode_e                      mode    [NUM_LEDS];
    logic [PWM_BITS-1:0]        level   [NUM_LEDS];
    logic [STRETCH_LOG2:0]      stretch [NUM_LEDS];
    logic [NUM_LEDS-1:0]        pwm_on;
    logic [NUM_LEDS-1:0]        lit;
    logic [IDX_W-1:0]           cfg_idx;
    logic                       cfg_hit;

    assign cfg_idx = cfg.CFG_IDX;
    assign cfg_hit = cfg.CFG_WE && (32'(cfg_idx) < NUM_LEDS);

    // The button is asynchronous. deb changes only after the synchronised
    // level has differed from deb for a full counter wrap.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync <= 2'b11;
            deb  <= 1'b1;
            dcnt <= '0;
        end else begin
            sync <= {sync[0], SW_N};
            if (sync[1] == deb) begin
                dcnt <= '0;
            end else if (dcnt == '1) begin
                deb  <= sync[1];
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rcnt <= '0;
        end else if (!deb) begin
            rcnt <= '0;
        end else if (!rcnt[RST_CYCLES_LOG2]) begin
            rcnt <= rcnt + 1'b1;
        end
    end

    assign SYS_RST = ~rcnt[RST_CYCLES_LOG2];

    // A button reset does not clear the config registers. Only RST_N does.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode[i]  <= MODE_OFF;
                level[i] <= '1;
            end
        end else if (cfg_hit) begin
            mode[cfg_idx]  <= mode_e'(cfg.CFG_MODE);
            level[cfg_idx] <= cfg.CFG_LEVEL;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
        end else if (SYS_RST) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // A new ACTIVITY pulse reloads the counter, even while it is still counting down.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_LEDS; i++) stretch[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (SYS_RST)                 stretch[i] <= '0;
                else if (ACTIVITY[i])        stretch[i] <= STRETCH_LOAD;
                else if (stretch[i] != '0)   stretch[i] <= stretch[i] - 1'b1;
            end
        end
    end

    always_comb begin
        pwm_on = '0;
        lit    = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            pwm_on[i] = (level[i] == '1) || (pwm_cnt < level[i]);
            case (mode[i])
                MODE_ON:    lit[i] = pwm_on[i];
                MODE_BLINK: lit[i] = pwm_on[i] & blink_cnt[BLINK_DIV_LOG2-1];
                MODE_ACT:   lit[i] = pwm_on[i] & (stretch[i] != '0);
                default:    lit[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LED <= RST_PATTERN ^ {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            LED <= (SYS_RST ? RST_PATTERN : lit) ^ {NUM_LEDS{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed testbench for led_ctrl. It checks {SYS_RST, LED} once per cycle
// against expected values held in a queue.
module tb_led_ctrl;

    localparam int NUM_LEDS        = 3;
    localparam int IDX_W           = 2;
    localparam int RST_CYCLES_LOG2 = 4;
    localparam int DEBOUNCE_LOG2   = 2;
    localparam int PWM_BITS        = 4;
    localparam int BLINK_DIV_LOG2  = 3;
    localparam int STRETCH_LOG2    = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sw_n;
    logic                sys_rst;
    logic [NUM_LEDS-1:0] activity;
    logic [NUM_LEDS-1:0] led;

    led_ctrl_if #(.IDX_W(IDX_W), .PWM_BITS(PWM_BITS)) cfg ();

    led_ctrl #(
        .NUM_LEDS(NUM_LEDS), .IDX_W(IDX_W), .RST_CYCLES_LOG2(RST_CYCLES_LOG2),
        .DEBOUNCE_LOG2(DEBOUNCE_LOG2), .PWM_BITS(PWM_BITS),
        .BLINK_DIV_LOG2(BLINK_DIV_LOG2), .STRETCH_LOG2(STRETCH_LOG2),
        .RST_PATTERN(3'b101), .ACTIVE_LOW(1'b0)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .SW_N(sw_n), .SYS_RST(sys_rst),
        .cfg(cfg), .ACTIVITY(activity), .LED(led)
    );

    always #5 clk = ~clk;

    // Each entry is {mask[3:0], value[3:0]}. Bit 3 is SYS_RST and bits 2:0 are LED.
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         e        = 0;   // rising edges since RST_N was released

    // pc() gives the pwm/blink counter value that the LED uses on the next edge.
    function automatic int pc();
        return e - 16;
    endfunction

    function automatic logic on_lvl(input int l);
        return (l == 15) || ((pc() & 15) < l);
    endfunction

    function automatic logic blink();
        return (pc() & 7) >= 4;
    endfunction

    // Expected value once channels 0/1/2 are set to ON-15, BLINK-15 and ACTIVITY-15.
    function automatic logic [3:0] ex(input logic l2);
        return {1'b0, l2, blink(), 1'b1};
    endfunction

    task automatic cyc(input logic [3:0] mask, input logic [3:0] val, input string nm);
        e++;
        exp_q.push_back({mask, val});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [1:0] idx, input logic [1:0] md, input logic [3:0] lvl);
        cfg.CFG_WE    = 1'b1;
        cfg.CFG_IDX   = idx;
        cfg.CFG_MODE  = md;
        cfg.CFG_LEVEL = lvl;
    endtask

    initial begin : monitor
        logic [7:0] ent;
        logic [3:0] got;
        string      nm;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                ent = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {sys_rst, led};
                if (ent[7:4] != 4'b0000) begin
                    n_checks++;
                    if ((got & ent[7:4]) == (ent[3:0] & ent[7:4])) n_pass++;
                    else $display("FAIL %s: got {sys_rst,led}=%b expected %b (mask %b)",
                                  nm, got, ent[3:0], ent[7:4]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : driver
        rst_n = 1'b0; sw_n = 1'b1; activity = '0;
        cfg.CFG_WE = 1'b0; cfg.CFG_IDX = '0; cfg.CFG_MODE = '0; cfg.CFG_LEVEL = '0;
        for (int i = 0; i < 3; i++) cyc(4'hF, 4'b1101, "rst_n_low");

        // Power-on reset sequence
        rst_n = 1'b1; e = 0;
        for (int i = 0; i < 15; i++) cyc(4'hF, 4'b1101, "por_hold");
        cyc(4'hF, 4'b0101, "por_release");
        cyc(4'hF, 4'b0000, "por_first_lit");

        // Channel 0 ON: level 4, then 0, then 15
        write_cfg(2'd0, 2'd1, 4'd4);
        cyc(4'hF, 4'b0000, "cfg_latency");
        cfg.CFG_WE = 1'b0;
        for (int i = 0; i < 16; i++) cyc(4'hF, {3'b000, on_lvl(4)}, "on_lvl4");
        write_cfg(2'd0, 2'd1, 4'd0);
        cyc(4'hF, {3'b000, on_lvl(4)}, "lvl_switch0");
        cfg.CFG_WE = 1'b0;
        for (int i = 0; i < 8; i++) cyc(4'hF, 4'b0000, "on_lvl0");
        write_cfg(2'd0, 2'd1, 4'd15);
        cyc(4'hF, 4'b0000, "lvl_switch15");
        cfg.CFG_WE = 1'b0;
        for (int i = 0; i < 8; i++) cyc(4'hF, 4'b0001, "on_lvl15");

        // Channel 1 BLINK
        write_cfg(2'd1, 2'd2, 4'd15);
        cyc(4'hF, 4'b0001, "blink_latency");
        cfg.CFG_WE = 1'b0;
        for (int i = 0; i < 16; i++) cyc(4'hF, {2'b00, blink(), 1'b1}, "blink");

        // Channel 2 ACTIVITY: a single pulse, then a retrigger on lit cycle 5
        write_cfg(2'd2, 2'd3, 4'd15);
        cyc(4'hF, ex(1'b0), "act_cfg");
        cfg.CFG_WE = 1'b0;
        for (int i = 0; i < 2; i++) cyc(4'hF, ex(1'b0), "act_idle");
        activity[2] = 1'b1;
        cyc(4'hF, ex(1'b0), "act_pulse");
        activity[2] = 1'b0;
        for (int i = 0; i < 8; i++) cyc(4'hF, ex(1'b1), "act_stretch");
        for (int i = 0; i < 2; i++) cyc(4'hF, ex(1'b0), "act_expire");
        activity[2] = 1'b1;
        cyc(4'hF, ex(1'b0), "act_pulse2");
        activity[2] = 1'b0;
        for (int i = 0; i < 4; i++) cyc(4'hF, ex(1'b1), "act_lit");
        activity[2] = 1'b1;
        cyc(4'hF, ex(1'b1), "act_retrig");
        activity[2] = 1'b0;
        for (int i = 0; i < 8; i++) cyc(4'hF, ex(1'b1), "act_restretch");
        cyc(4'hF, ex(1'b0), "act_expire2");

        // A write to an out-of-range index must not change any channel
        write_cfg(2'd3, 2'd0, 4'd0);
        cyc(4'hF, ex(1'b0), "bad_idx");
        cfg.CFG_WE = 1'b0;
        for (int i = 0; i < 4; i++) cyc(4'hF, ex(1'b0), "bad_idx_after");

        // Button glitch shorter than the debounce window
        sw_n = 1'b0;
        for (int i = 0; i < 3; i++) cyc(4'hF, ex(1'b0), "glitch");
        sw_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc(4'hF, ex(1'b0), "glitch_ignored");

        // Real press held for 10 cycles, then release
        sw_n = 1'b0;
        for (int i = 0; i < 6; i++) cyc(4'hF, ex(1'b0), "press_debounce");
        cyc(4'hF, {1'b1, 1'b0, blink(), 1'b1}, "press_sys_rst");
        for (int i = 0; i < 3; i++) cyc(4'hF, 4'b1101, "press_hold");
        sw_n = 1'b1;
        for (int i = 0; i < 21; i++) cyc(4'hF, 4'b1101, "release_hold");
        cyc(4'hF, 4'b0101, "release_end");
        for (int j = 0; j < 8; j++) cyc(4'hF, {2'b00, (j >= 4), 1'b1}, "resume");

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_ctrl.md
# led_ctrl

Parametrised board status block: generates the system reset from the board reset and a debounced push-button, and drives NUM_LEDS status LEDs, each with its own mode (off / on / blink / activity-stretch) and PWM brightness. Sits at the top level next to the clock input and feeds SYS_RST to every other block (ULPI, SDRAM, host interface). Replaces the fixed per-LED wiring and the hard-coded power-on counter of the previous generation.

## Interface
- NUM_LEDS, 3, number of LED channels (1..16)
- IDX_W, 2, CFG_IDX width; must satisfy 2^IDX_W >= NUM_LEDS
- RST_CYCLES_LOG2, 25, SYS_RST is held for 2^RST_CYCLES_LOG2 cycles after reset/button release
- DEBOUNCE_LOG2, 16, button must be stable 2^DEBOUNCE_LOG2 cycles to register
- PWM_BITS, 8, brightness resolution
- BLINK_DIV_LOG2, 23, blink period = 2^BLINK_DIV_LOG2 cycles, 50 % duty
- STRETCH_LOG2, 22, activity pulse stretched to 2^STRETCH_LOG2 cycles
- RST_PATTERN, 3'b101, logical LED pattern shown while SYS_RST is high
- ACTIVE_LOW, 0, 1 = invert all LED outputs
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- SW_N  in  1  push-button, active low, asynchronous to CLK
- SYS_RST  out  1  active-high system reset, registered
- CFG_WE  in  1  write strobe for one channel's configuration
- CFG_IDX  in  IDX_W  channel being written
- CFG_MODE  in  2  0 OFF, 1 ON, 2 BLINK, 3 ACTIVITY
- CFG_LEVEL  in  PWM_BITS  brightness
- ACTIVITY  in  NUM_LEDS  per-channel event strobes, synchronous to CLK
- LED  out  NUM_LEDS  registered LED drive

## Operation
- Button path: 2-FF synchroniser, then debouncer. deb resets to 1 (released). Counter dcnt (DEBOUNCE_LOG2 bits) increments while sync != deb and clears while sync == deb. When dcnt is all ones and sync != deb: deb <= sync, dcnt <= 0.
- Reset counter rcnt (RST_CYCLES_LOG2+1 bits): cleared by RST_N or while deb == 0; otherwise increments until bit RST_CYCLES_LOG2 is set, then holds. SYS_RST = ~rcnt[MSB].
- Config: per channel, mode (reset 0) and level (reset all ones). CFG_WE with CFG_IDX < NUM_LEDS updates that channel on the clock edge. CFG_IDX >= NUM_LEDS: write ignored. Writes are accepted during SYS_RST.
- Free-running pwm_cnt (PWM_BITS) and blink_cnt (BLINK_DIV_LOG2) increment every cycle. Both are held at 0 while SYS_RST is high.
- pwm_on(i) = (level == all ones) | (pwm_cnt < level). Level 0 means always dark.
- Stretch counter per channel (STRETCH_LOG2+1 bits): loads 2^STRETCH_LOG2 when ACTIVITY[i] is high (retrigger reloads), otherwise decrements toward 0. Held at 0 during SYS_RST. Runs in every mode.
- lit(i) by mode:
  - OFF: 0
  - ON: pwm_on
  - BLINK: pwm_on & blink_cnt[MSB]
  - ACTIVITY: pwm_on & (stretch != 0)
- LED[i] <= (SYS_RST ? RST_PATTERN[i] : lit(i)) ^ ACTIVE_LOW.

## Timing
- Reset values while RST_N is low:
  - SYS_RST = 1
  - LED = RST_PATTERN ^ {NUM_LEDS{ACTIVE_LOW}}
  - all counters = 0
  - deb = 1
  - sync FFs = 1
- RST_N deasserted: SYS_RST falls after exactly 2^RST_CYCLES_LOG2 rising edges.
- SW_N change held stable: deb changes 2 + 2^DEBOUNCE_LOG2 edges later. Glitches shorter than 2^DEBOUNCE_LOG2 cycles (after the synchroniser) are ignored.
- Button press: SYS_RST rises 1 cycle after deb falls and stays high while the button is held. On release it stays high for a further 2^RST_CYCLES_LOG2 cycles after deb rises.
- Reset mid-operation: config registers survive a button reset; only RST_N clears them.
- Config write at edge k affects LED from edge k+1 (1-cycle register latency).
- ACTIVITY high at edge k (mode ACTIVITY, level all ones): LED lit from edge k+1 for 2^STRETCH_LOG2 cycles. A simultaneous reload and decrement resolves as reload.
- SYS_RST falling: LED switches from RST_PATTERN to lit() on the next edge.

## Test plan
Bench parameters: NUM_LEDS=3, RST_CYCLES_LOG2=4, DEBOUNCE_LOG2=2, PWM_BITS=4, BLINK_DIV_LOG2=3, STRETCH_LOG2=3, RST_PATTERN=3'b101, ACTIVE_LOW=0.

1. Release RST_N -> SYS_RST=1 and LED=101 for 16 edges, then SYS_RST=0; next edge LED=000.
2. SW_N low for 3 cycles -> no SYS_RST. SW_N low for 10 cycles -> SYS_RST high 7 edges after the fall; after release, high for 6+16 further edges.
3. Channel 0 ON, level 4 -> LED[0] high for 4 of every 16 cycles. Level 0 -> constantly 0. Level 15 -> constantly 1.
4. Channel 1 BLINK, level 15 -> LED[1] alternates: 4 cycles low, 4 cycles high, aligned to blink_cnt[2].
5. Channel 2 ACTIVITY, level 15, single ACTIVITY[2] pulse -> 8 lit cycles. Second pulse at lit cycle 5 -> lit for 8 cycles after the second pulse.
6. CFG_WE with CFG_IDX=3 -> no channel changes. Button reset with channel 0 in ON -> LED=101 during reset, then ON resumes.
